// File: rtl/sar_avg_ctrl_pkg.sv
// sar_pkg: shared types and constants for the SAR averaging controller.
//   state_e  : controller FSM states
//   ADC_W    : SAR result width
//   SUM_W    : block sum width (16 * 1023 fits)
//   OSR_MAX  : largest usable oversampling exponent
package sar_pkg;
    localparam int ADC_W   = 10;
    localparam int SUM_W   = 14;
    localparam int OSR_MAX = 4;

    typedef enum logic [2:0] {IDLE, CAL_REQ, CAL_WAIT, CONV_REQ, CONV_WAIT} state_e;

    // Exponents above OSR_MAX would overflow the sum, so they are clamped.
    function automatic logic [2:0] osr_clip(input logic [2:0] o);
        return o > 3'(OSR_MAX) ? 3'(OSR_MAX) : o;
    endfunction
endpackage

// File: rtl/sar_avg_ctrl_if.sv
// sar_avg_ctrl_if: control, SAR and result-stream signals of the averaging controller.
//   slave  : controller side (sar_avg_ctrl)
//   master : environment side (control source, SAR logic, stream sink)
interface sar_avg_ctrl_if;
    import sar_pkg::*;
    logic             start;
    logic [2:0]       osr_log2;
    logic             cal_req;
    logic             err_clr;
    logic             adc_en;
    logic             adc_cal;
    logic             adc_valid;
    logic [ADC_W-1:0] adc_result;
    logic             m_valid;
    logic             m_ready;
    logic [ADC_W-1:0] m_data;
    logic [SUM_W-1:0] m_sum;
    logic             overflow;
    logic             timeout;
    logic             cal_busy;

    modport slave (
        input  start, osr_log2, cal_req, err_clr, adc_valid, adc_result, m_ready,
        output adc_en, adc_cal, m_valid, m_data, m_sum, overflow, timeout, cal_busy
    );
    modport master (
        output start, osr_log2, cal_req, err_clr, adc_valid, adc_result, m_ready,
        input  adc_en, adc_cal, m_valid, m_data, m_sum, overflow, timeout, cal_busy
    );
endinterface

// File: rtl/sar_result_fifo.sv
// sar_result_fifo: synchronous FIFO for averaged block results.
//   push_i/data_i : write request and entry
//   pop_i         : read request, head advances when non-empty
//   data_o        : head entry, 0 when empty
//   full_o/empty_o: occupancy flags
module sar_result_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          wr, rd;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign rd      = pop_i && !empty_o;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign wr      = push_i && (!full_o || rd);
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr ? wr_q + AW'(1) : wr_q;
            rd_q  <= rd ? rd_q + AW'(1) : rd_q;
            cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/sar_avg_ctrl.sv
// sar_avg_ctrl: sequences SAR calibrations and conversions, averages 2^osr samples per block
// and queues {sum, sum>>osr} results on a ready/valid stream.
//   clk, rstn : clock, asynchronous active-low reset
//   bus_io    : control inputs, SAR request/response, result stream and status flags
module sar_avg_ctrl
    import sar_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int RECAL_PERIOD = 256,
    parameter int TIMEOUT      = 64
) (
    input logic           clk,
    input logic           rstn,
    sar_avg_ctrl_if.slave bus_io
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int EW = SUM_W + ADC_W;

    state_e           state_q, state_d;
    logic             pend_q, pend_d, ovf_q, ovf_d, tmo_q, tmo_d, push_q, push_d, tmo_set;
    logic [SUM_W-1:0] acc_q, acc_d, sum_n;
    logic [4:0]       cnt_q, cnt_d, cnt_n;
    logic [2:0]       osr_q, osr_d;
    logic [15:0]      blk_q, blk_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [EW-1:0]    ent_q, ent_d, head;
    logic             full, empty, last, tmo_hit;

    assign sum_n   = acc_q + SUM_W'(bus_io.adc_result);
    assign cnt_n   = cnt_q + 5'd1;
    assign last    = cnt_n == (5'd1 << osr_q);
    assign tmo_hit = tmr_q == TW'(TIMEOUT - 1);
    // Set events take priority over err_clr in the same cycle.
    assign ovf_d   = (push_q & full & ~bus_io.m_ready) | (ovf_q & ~bus_io.err_clr);
    assign tmo_d   = tmo_set | (tmo_q & ~bus_io.err_clr);

    assign bus_io.adc_en   = state_q == CAL_REQ || state_q == CONV_REQ;
    assign bus_io.adc_cal  = state_q == CAL_REQ;
    assign bus_io.cal_busy = state_q == CAL_REQ || state_q == CAL_WAIT;
    assign bus_io.m_valid  = !empty;
    assign bus_io.overflow = ovf_q;
    assign bus_io.timeout  = tmo_q;
    assign {bus_io.m_sum, bus_io.m_data} = head;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q | bus_io.cal_req;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        osr_d   = osr_q;
        blk_d   = blk_q;
        tmr_d   = tmr_q;
        ent_d   = ent_q;
        push_d  = 1'b0;
        tmo_set = 1'b0;
        case (state_q)
            IDLE: begin
                acc_d = '0;
                cnt_d = '0;
                if (bus_io.start) state_d = pend_d ? CAL_REQ : CONV_REQ;
            end
            CAL_REQ: begin
                tmr_d   = '0;
                state_d = CAL_WAIT;
            end
            CONV_REQ: begin
                tmr_d   = '0;
                // The exponent is frozen for the whole block at its first request.
                if (cnt_q == '0) osr_d = osr_clip(bus_io.osr_log2);
                state_d = CONV_WAIT;
            end
            CAL_WAIT: begin
                if (bus_io.adc_valid) begin
                    pend_d  = bus_io.cal_req;
                    state_d = bus_io.start ? CONV_REQ : IDLE;
                end else if (tmo_hit) begin
                    tmo_set = 1'b1;
                    state_d = IDLE;
                end else tmr_d = tmr_q + TW'(1);
            end
            CONV_WAIT: begin
                if (bus_io.adc_valid && last) begin
                    push_d = 1'b1;
                    ent_d  = {sum_n, ADC_W'(sum_n >> osr_q)};
                    acc_d  = '0;
                    cnt_d  = '0;
                    if (blk_q == 16'(RECAL_PERIOD - 1)) begin
                        blk_d  = '0;
                        pend_d = 1'b1;
                    end else blk_d = blk_q + 16'd1;
                    state_d = !bus_io.start ? IDLE : pend_d ? CAL_REQ : CONV_REQ;
                end else if (bus_io.adc_valid) begin
                    acc_d   = bus_io.start ? sum_n : '0;
                    cnt_d   = bus_io.start ? cnt_n : '0;
                    state_d = bus_io.start ? CONV_REQ : IDLE;
                end else if (tmo_hit) begin
                    tmo_set = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else tmr_d = tmr_q + TW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            pend_q  <= 1'b1;
            acc_q   <= '0;
            cnt_q   <= '0;
            osr_q   <= '0;
            blk_q   <= '0;
            tmr_q   <= '0;
            ent_q   <= '0;
            push_q  <= 1'b0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            osr_q   <= osr_d;
            blk_q   <= blk_d;
            tmr_q   <= tmr_d;
            ent_q   <= ent_d;
            push_q  <= push_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
        end
    end

    sar_result_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rstn   (rstn),
        .push_i (push_q),
        .data_i (ent_q),
        .pop_i  (bus_io.m_ready),
        .data_o (head),
        .full_o (full),
        .empty_o(empty)
    );
endmodule

// File: tb/tb_sar_avg_ctrl.sv
// tb_sar_avg_ctrl: directed scoreboard bench for sar_avg_ctrl (default instance plus a RECAL_PERIOD=2 instance).
module tb_sar_avg_ctrl;
    import sar_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int total = 0;
    int bad = 0;
    logic [SUM_W+ADC_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    sar_avg_ctrl_if b1();
    sar_avg_ctrl_if b2();

    sar_avg_ctrl dut (.clk(clk), .rstn(rstn), .bus_io(b1));
    sar_avg_ctrl #(.FIFO_DEPTH(4), .RECAL_PERIOD(2), .TIMEOUT(64)) dut2 (.clk(clk), .rstn(rstn), .bus_io(b2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_en(input bit w, input bit exp_cal);
        int n = 0;
        while (!(w ? b2.adc_en : b1.adc_en) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("adc_en", w ? b2.adc_en : b1.adc_en, 1);
        chk("adc_cal", w ? b2.adc_cal : b1.adc_cal, 32'(exp_cal));
        chk("cal_busy", w ? b2.cal_busy : b1.cal_busy, 32'(exp_cal));
    endtask

    task automatic sar_ret(input bit w, input int v, input bit stop);
        repeat (2) @(negedge clk);
        if (w) begin
            b2.adc_valid = 1'b1;
            b2.adc_result = 10'(v);
            if (stop) b2.start = 1'b0;
        end else begin
            b1.adc_valid = 1'b1;
            b1.adc_result = 10'(v);
            if (stop) b1.start = 1'b0;
        end
        @(negedge clk);
        b1.adc_valid = 1'b0;
        b2.adc_valid = 1'b0;
    endtask

    task automatic conv(input bit w, input int v, input bit cal, input bit stop);
        wait_en(w, cal);
        sar_ret(w, v, stop);
    endtask

    task automatic expect_blk(input int sum, input int osr);
        exp_q.push_back({SUM_W'(sum), ADC_W'(sum >> osr)});
    endtask

    task automatic pop_chk(input bit w);
        logic [SUM_W+ADC_W-1:0] e = '1;
        int n = 0;
        while (!(w ? b2.m_valid : b1.m_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("m_valid", w ? b2.m_valid : b1.m_valid, 1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk("m_sum", w ? b2.m_sum : b1.m_sum, 32'(e[SUM_W+ADC_W-1:ADC_W]));
        chk("m_data", w ? b2.m_data : b1.m_data, 32'(e[ADC_W-1:0]));
        if (w) b2.m_ready = 1'b1;
        else b1.m_ready = 1'b1;
        @(negedge clk);
        b1.m_ready = 1'b0;
        b2.m_ready = 1'b0;
    endtask

    initial begin
        int s;
        {b1.start, b1.osr_log2, b1.cal_req, b1.err_clr, b1.adc_valid, b1.adc_result, b1.m_ready} = '0;
        {b2.start, b2.osr_log2, b2.cal_req, b2.err_clr, b2.adc_valid, b2.adc_result, b2.m_ready} = '0;
        repeat (3) @(negedge clk);
        chk("rst_adc_en", b1.adc_en, 0);
        chk("rst_adc_cal", b1.adc_cal, 0);
        chk("rst_cal_busy", b1.cal_busy, 0);
        chk("rst_m_valid", b1.m_valid, 0);
        chk("rst_m_data", b1.m_data, 0);
        chk("rst_m_sum", b1.m_sum, 0);
        chk("rst_overflow", b1.overflow, 0);
        chk("rst_timeout", b1.timeout, 0);
        rstn = 1'b1;
        @(negedge clk);
        // stray completion while idle must be ignored
        b1.adc_valid = 1'b1;
        b1.adc_result = 10'd300;
        @(negedge clk);
        b1.adc_valid = 1'b0;
        @(negedge clk);
        chk("stray_adc_en", b1.adc_en, 0);
        chk("stray_m_valid", b1.m_valid, 0);

        // first request is a calibration, then a single-sample block
        b1.osr_log2 = 3'd0;
        b1.start = 1'b1;
        conv(0, 7, 1, 0);
        conv(0, 512, 0, 1);
        expect_blk(512, 0);
        chk("lat_early", b1.m_valid, 0);
        @(negedge clk);
        chk("lat_rise", b1.m_valid, 1);
        pop_chk(0);
        chk("empty_valid", b1.m_valid, 0);
        chk("empty_data", b1.m_data, 0);
        chk("empty_sum", b1.m_sum, 0);

        // osr=2: four samples
        b1.osr_log2 = 3'd2;
        b1.start = 1'b1;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            conv(0, 100 + i, 0, i == 3);
            s += 100 + i;
        end
        expect_blk(s, 2);
        pop_chk(0);

        // osr=4 full scale
        b1.osr_log2 = 3'd4;
        b1.start = 1'b1;
        for (int i = 0; i < 16; i++) conv(0, 1023, 0, i == 15);
        expect_blk(16 * 1023, 4);
        pop_chk(0);

        // osr change mid-block waits for the next block
        b1.osr_log2 = 3'd1;
        b1.start = 1'b1;
        conv(0, 10, 0, 0);
        b1.osr_log2 = 3'd3;
        conv(0, 21, 0, 1);
        expect_blk(31, 1);
        pop_chk(0);

        // osr=7 behaves as 4
        b1.osr_log2 = 3'd7;
        b1.start = 1'b1;
        s = 0;
        for (int i = 0; i < 16; i++) begin
            conv(0, 60 * i, 0, i == 15);
            s += 60 * i;
        end
        expect_blk(s, 4);
        pop_chk(0);

        // start dropped mid-block: partial sum discarded
        b1.osr_log2 = 3'd2;
        b1.start = 1'b1;
        conv(0, 50, 0, 0);
        conv(0, 60, 0, 0);
        conv(0, 70, 0, 1);
        repeat (4) @(negedge clk);
        chk("partial_m_valid", b1.m_valid, 0);
        chk("partial_adc_en", b1.adc_en, 0);
        b1.osr_log2 = 3'd0;
        b1.start = 1'b1;
        conv(0, 9, 0, 1);
        expect_blk(9, 0);
        pop_chk(0);

        // overflow: five blocks into a four-entry FIFO
        for (int k = 0; k < 5; k++) begin
            b1.start = 1'b1;
            conv(0, 200 + k, 0, 1);
            if (k < 4) expect_blk(200 + k, 0);
        end
        repeat (2) @(negedge clk);
        chk("ovf_set", b1.overflow, 1);
        b1.err_clr = 1'b1;
        @(negedge clk);
        b1.err_clr = 1'b0;
        chk("ovf_clr", b1.overflow, 0);
        b1.start = 1'b1;
        conv(0, 260, 0, 1);
        pop_chk(0);
        expect_blk(260, 0);
        chk("ovf_push_pop", b1.overflow, 0);
        for (int k = 0; k < 4; k++) pop_chk(0);
        chk("ovf_drained", b1.m_valid, 0);

        // cal_req mid-block at osr=3, then calibration times out
        b1.osr_log2 = 3'd3;
        b1.start = 1'b1;
        s = 0;
        for (int i = 1; i <= 8; i++) begin
            wait_en(0, 0);
            if (i == 4) begin
                b1.cal_req = 1'b1;
                @(negedge clk);
                b1.cal_req = 1'b0;
            end
            sar_ret(0, i, 0);
            s += i;
        end
        expect_blk(s, 3);
        wait_en(0, 1);
        b1.start = 1'b0;
        repeat (64) @(negedge clk);
        chk("tmo_early", b1.timeout, 0);
        @(negedge clk);
        chk("tmo_set", b1.timeout, 1);
        chk("tmo_adc_en", b1.adc_en, 0);
        chk("tmo_cal_busy", b1.cal_busy, 0);
        pop_chk(0);
        b1.err_clr = 1'b1;
        @(negedge clk);
        b1.err_clr = 1'b0;
        chk("tmo_clr", b1.timeout, 0);
        b1.osr_log2 = 3'd0;
        b1.start = 1'b1;
        conv(0, 0, 1, 0);
        conv(0, 33, 0, 1);
        expect_blk(33, 0);
        pop_chk(0);

        // asynchronous reset during a conversion
        b1.osr_log2 = 3'd2;
        b1.start = 1'b1;
        wait_en(0, 0);
        #3 rstn = 1'b0;
        #1;
        chk("arst_adc_en", b1.adc_en, 0);
        chk("arst_cal_busy", b1.cal_busy, 0);
        chk("arst_m_valid", b1.m_valid, 0);
        b1.start = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        b1.osr_log2 = 3'd0;
        b1.start = 1'b1;
        conv(0, 5, 1, 0);
        conv(0, 77, 0, 1);
        expect_blk(77, 0);
        pop_chk(0);

        // RECAL_PERIOD=2: calibration before blocks 0, 2, 4
        b2.osr_log2 = 3'd0;
        for (int k = 0; k < 6; k++) begin
            b2.start = 1'b1;
            if (k % 2 == 0) conv(1, 3, 1, 0);
            conv(1, 100 + k, 0, 1);
            expect_blk(100 + k, 0);
            pop_chk(1);
        end
        chk("recal_empty", b2.m_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sar_avg_ctrl.md
SAR_AVG_CTRL -- requirements
Module: sar_avg_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: output FIFO entries; power of two, 2..16.
REQ-002 Parameter RECAL_PERIOD, default 256: averaged blocks between automatic recalibrations, 1..65535.
REQ-003 Parameter TIMEOUT, default 64: cycles allowed from adc_en to adc_valid.
REQ-004 Reset rstn, asynchronous, active-low; clock clk.
REQ-005 clk  input  1  block clock, same clock as the SAR logic.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 start  input  1  level; 1 = run continuous averaged conversions.
REQ-008 osr_log2  input  3  oversampling exponent; values above 4 are treated as 4.
REQ-009 cal_req  input  1  single-cycle calibration request.
REQ-010 err_clr  input  1  single-cycle clear of the sticky overflow and timeout flags.
REQ-011 adc_en  output  1  conversion request pulse to the SAR logic.
REQ-012 adc_cal  output  1  calibration qualifier, driven high only together with adc_en.
REQ-013 adc_valid  input  1  SAR completion pulse.
REQ-014 adc_result  input  10  SAR result, sampled only when adc_valid=1.
REQ-015 m_valid / m_ready  output / input  1 / 1  output stream handshake.
REQ-016 m_data  output  10  averaged result, sum >> osr.
REQ-017 m_sum  output  14  raw block sum.
REQ-018 overflow, timeout, cal_busy  output  1 each  sticky FIFO-drop flag; sticky missing-valid flag; calibration in progress.

Function
REQ-019 States: IDLE, CAL_REQ, CAL_WAIT, CONV_REQ, CONV_WAIT.
- IDLE: start=1 and calibration pending -> CAL_REQ; start=1 otherwise -> CONV_REQ.
- A calibration is pending after reset.
REQ-020 CAL_REQ / CONV_REQ: drive adc_en=1 for exactly one cycle, plus adc_cal=1 in CAL_REQ, then go to the matching WAIT state.
REQ-021 CAL_WAIT:
- cal_busy=1 from CAL_REQ entry until adc_valid.
- On adc_valid: clear the pending calibration, discard adc_result, go to CONV_REQ (start=1) or IDLE.
REQ-022 CONV_WAIT, on adc_valid:
- Add adc_result to the 14-bit accumulator and increment the sample count.
- If count reaches 2^osr, close the block; else go to CONV_REQ.
REQ-023 osr_log2 is latched at block start; changes take effect at the next block.
REQ-024 Closing a block:
- Push {sum, sum>>osr} to the FIFO in the cycle after the final adc_valid.
- Clear the accumulator.
- Increment the block counter.
REQ-025 Block counter reaching RECAL_PERIOD sets calibration pending and wraps to 0.
REQ-026 cal_req in any state sets calibration pending.
- The current block always completes first.
- Calibration starts before the next block.
REQ-027 start deasserted mid-block:
- The outstanding conversion completes.
- The partial sum is discarded, with no push.
- Return to IDLE.
REQ-028 No adc_valid within TIMEOUT cycles of adc_en:
- Set timeout.
- Discard the partial block.
- Go to IDLE.
- Keep calibration pending if the timeout happened in CAL_WAIT.
REQ-029 adc_valid outside the WAIT states is ignored.
REQ-030 FIFO handshake:
- m_valid=1 while non-empty.
- Pop on m_valid and m_ready.
- m_data and m_sum show the head entry and are 0 when empty.
REQ-031 Push while full with no pop in that cycle: the entry is dropped and overflow is set.
REQ-032 Push and pop in the same cycle while full: both succeed and overflow is not set.
REQ-033 err_clr clears overflow and timeout.
- A set event in the same cycle wins over err_clr.
REQ-034 Maximum sum is 16*1023=16368, so it fits 14 bits and no saturation is needed.
REQ-035 Latency: m_valid rises 2 cycles after the final adc_valid of a block when the FIFO was empty.

Reset
REQ-036 rstn low asynchronously forces the following, regardless of an in-flight SAR conversion:
- state=IDLE.
- adc_en=0, adc_cal=0, cal_busy=0.
- FIFO empty, m_valid=0, m_data=0, m_sum=0.
- Accumulator, sample counter and block counter = 0.
- overflow=0, timeout=0.
- Calibration pending=1.
REQ-037 After rstn releases, the first adc_en is issued with adc_cal=1.

Structure
REQ-038 Package sar_pkg holds:
- The state enum.
- ADC_W=10, SUM_W=14, OSR_MAX=4.
REQ-039 The FIFO is a sub-module, sar_result_fifo.
- Parameterised on width and depth.
- Provides full/empty and push/pop ports.

Verification
REQ-040 Reset release, start=1, osr=0 -> first adc_en carries adc_cal=1; then the SAR returns 512 -> m_data=512, m_sum=512.
REQ-041 osr=2, SAR returns 100, 101, 102, 103 -> one entry, m_sum=406, m_data=101.
REQ-042 osr=4, all samples 1023 -> m_sum=16368, m_data=1023.
REQ-043 Depth 4, m_ready=0, 5 blocks -> overflow=1 and 4 entries held; m_ready=1 together with a 6th push while full -> no new overflow.
REQ-044 cal_req mid-block at osr=3 -> 8 samples complete first, then adc_en+adc_cal; no adc_valid for 64 cycles -> timeout=1, IDLE, calibration still pending.
REQ-045 RECAL_PERIOD=2 -> calibration cycles occur exactly before blocks 0, 2 and 4.
